frac_bits_seq_ctrl: RTL and testbench

FRAC_BITS_SEQ_CTRL -- requirements
Module: frac_bits_seq_ctrl

---
 rtl/frac_ctrl_pkg.sv | 14 +
 rtl/frac_word_counter.sv | 34 +++
 rtl/frac_bits_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_frac_bits_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/frac_ctrl_pkg.sv
// Shared definitions for the fraction-bits sequencer: state encoding and default widths.
package frac_ctrl_pkg;

    localparam int unsigned DefAddrWidth = 7;
    localparam int unsigned DefIterWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StGap,
        StFin
    } frac_state_e;

endpackage

// File: rtl/frac_word_counter.sv
// Word counter for one residue sweep; flags the last word against a latched limit.
module frac_word_counter
    import frac_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  clear,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] limit,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  at_last
);

    localparam logic [ADDR_WIDTH-1:0] WordOne = 1;

    logic [ADDR_WIDTH-1:0] cnt_q;

    // Never wraps by overflow: the controller clears it once at_last is reached.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + WordOne;
        end
    end

    assign cnt     = cnt_q;
    assign at_last = (cnt_q == limit);

endmodule

// File: rtl/frac_bits_seq_ctrl.sv
// Sequencer for the fraction-bits residue store: sweeps num_words words per iteration,
// with a one-cycle gap between sweeps, for num_iters iterations.
module frac_bits_seq_ctrl
    import frac_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned ITER_WIDTH = DefIterWidth
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [ITER_WIDTH-1:0] num_iters,
    input  logic                  stall,
    input  logic                  abort,
    output logic                  enable,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  first_word,
    output logic                  last_word,
    output logic [ITER_WIDTH-1:0] iter_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0]   MaxWords = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   OneWord  = 1;
    localparam logic [ADDR_WIDTH-1:0] WordOne  = 1;
    localparam logic [ITER_WIDTH-1:0] IterOne  = 1;

    frac_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] limit_q, limit_d, limit_in;
    logic [ITER_WIDTH-1:0] iters_q, iters_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic [ADDR_WIDTH-1:0] w_cnt, w_nxt;
    logic                  w_at_last;
    logic                  wc_clear, wc_inc, advance;
    logic                  enable_q, enable_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH:0]   words_m1;

    // Stored limit is the index of the last word: 0 words behaves as 1, excess clamps to max.
    always_comb begin
        words_m1 = num_words - OneWord;
        if (num_words == '0) begin
            limit_in = '0;
        end else if (num_words > MaxWords) begin
            limit_in = '1;
        end else begin
            limit_in = words_m1[ADDR_WIDTH-1:0];
        end
    end

    frac_word_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_word_counter (
        .clk       (clk),
        .asyn_reset(asyn_reset),
        .clear     (wc_clear),
        .inc       (wc_inc),
        .limit     (limit_q),
        .cnt       (w_cnt),
        .at_last   (w_at_last)
    );

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        iters_d  = iters_q;
        iter_d   = iter_q;
        wc_clear = 1'b0;
        wc_inc   = 1'b0;
        advance  = (state_q == StIdle) || !stall;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    limit_d  = limit_in;
                    iters_d  = num_iters;
                    iter_d   = '0;
                    wc_clear = 1'b1;
                    state_d  = (num_iters == '0) ? StFin : StSweep;
                end
            end
            StSweep: begin
                if (!stall) begin
                    if (w_at_last) begin
                        state_d  = StGap;
                        wc_clear = 1'b1;
                        iter_d   = iter_q + IterOne;
                    end else begin
                        wc_inc = 1'b1;
                    end
                end
            end
            StGap: begin
                if (!stall) begin
                    state_d = (iter_q == iters_q) ? StFin : StSweep;
                end
            end
            StFin: begin
                if (!stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over stall and start, including a start in the same IDLE cycle.
        if (abort) begin
            state_d  = StIdle;
            limit_d  = limit_q;
            iters_d  = iters_q;
            iter_d   = '0;
            wc_clear = 1'b1;
            wc_inc   = 1'b0;
            advance  = 1'b0;
        end

        if (wc_clear) begin
            w_nxt = '0;
        end else if (wc_inc) begin
            w_nxt = w_cnt + WordOne;
        end else begin
            w_nxt = w_cnt;
        end

        enable_d = advance && (state_d == StSweep);
        first_d  = (state_d == StSweep) && (w_nxt == '0);
        last_d   = (state_d == StSweep) && (w_nxt == limit_d);
        busy_d   = (state_d != StIdle);
        done_d   = advance && (state_d == StFin);
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            limit_q  <= '0;
            iters_q  <= '0;
            iter_q   <= '0;
            enable_q <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            limit_q  <= limit_d;
            iters_q  <= iters_d;
            iter_q   <= iter_d;
            enable_q <= enable_d;
            first_q  <= first_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign enable     = enable_q;
    assign rd_addr    = w_cnt;
    assign wr_addr    = w_cnt;
    assign first_word = first_q;
    assign last_word  = last_q;
    assign iter_cnt   = iter_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_frac_bits_seq_ctrl.sv
// Directed bench for frac_bits_seq_ctrl; outputs sampled on the falling edge.
module tb_frac_bits_seq_ctrl;

    logic       clk = 1'b0;
    logic       asyn_reset;
    logic       start;
    logic [7:0] num_words;
    logic [7:0] num_iters;
    logic       stall;
    logic       abort;
    logic       enable;
    logic [6:0] rd_addr;
    logic [6:0] wr_addr;
    logic       first_word;
    logic       last_word;
    logic [7:0] iter_cnt;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_bad = 0;

    frac_bits_seq_ctrl #(
        .ADDR_WIDTH(7),
        .ITER_WIDTH(8)
    ) dut (
        .clk       (clk),
        .asyn_reset(asyn_reset),
        .start     (start),
        .num_words (num_words),
        .num_iters (num_iters),
        .stall     (stall),
        .abort     (abort),
        .enable    (enable),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr),
        .first_word(first_word),
        .last_word (last_word),
        .iter_cnt  (iter_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves the bench at the falling edge of cycle 1 after start.
    task automatic drive_start(input logic [7:0] nw, input logic [7:0] ni);
        @(negedge clk);
        start     = 1'b1;
        num_words = nw;
        num_iters = ni;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_long(input logic [7:0] nw, input string tag);
        drive_start(nw, 8'd1);
        check_val({tag, "_first"}, {31'd0, first_word}, 32'd1);
        repeat (127) tick();
        check_val({tag, "_addr"}, {25'd0, wr_addr}, 32'd127);
        check_val({tag, "_last"}, {31'd0, last_word}, 32'd1);
        check_val({tag, "_en"}, {31'd0, enable}, 32'd1);
        tick();
        check_val({tag, "_gap"}, {31'd0, enable}, 32'd0);
        tick();
        check_val({tag, "_done"}, {31'd0, done}, 32'd1);
        tick();
    endtask

    logic [8:0] exp_en3;
    logic [8:0] exp_dn3;
    int         exp_ad3[9];

    initial begin
        exp_en3 = 9'b001110111;  // bit c-1 for cycle c: 1,1,1,0,1,1,1,0,0
        exp_dn3 = 9'b100000000;
        exp_ad3 = '{0, 1, 2, 0, 0, 1, 2, 0, 0};
        asyn_reset = 1'b1;
        start      = 1'b0;
        num_words  = 8'd0;
        num_iters  = 8'd0;
        stall      = 1'b0;
        abort      = 1'b0;
        #12;
        check_val("rst_en", {31'd0, enable}, 32'd0);
        check_val("rst_addr", {18'd0, rd_addr, wr_addr}, 32'd0);
        check_val("rst_flags", {30'd0, first_word, last_word}, 32'd0);
        check_val("rst_iter", {24'd0, iter_cnt}, 32'd0);
        check_val("rst_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        asyn_reset = 1'b0;

        // 3 words x 2 iterations
        drive_start(8'd3, 8'd2);
        for (int c = 1; c <= 9; c++) begin
            check_val($sformatf("w3_en_c%0d", c), {31'd0, enable}, {31'd0, exp_en3[c-1]});
            if (exp_en3[c-1]) begin
                check_val($sformatf("w3_addr_c%0d", c), {25'd0, wr_addr}, exp_ad3[c-1]);
            end
            check_val($sformatf("w3_done_c%0d", c), {31'd0, done}, {31'd0, exp_dn3[c-1]});
            if (c < 9) tick();
        end
        tick();
        check_val("w3_idle_busy", {31'd0, busy}, 32'd0);

        // single word, single iteration
        drive_start(8'd1, 8'd1);
        check_val("w1_c1", {29'd0, enable, first_word, last_word}, 32'd7);
        tick();
        check_val("w1_gap_en", {31'd0, enable}, 32'd0);
        check_val("w1_gap_iter", {24'd0, iter_cnt}, 32'd1);
        tick();
        check_val("w1_done", {30'd0, busy, done}, 32'd3);
        tick();
        check_val("w1_idle", {30'd0, busy, done}, 32'd0);

        // 4 words, stall for two cycles while word 2 is presented
        drive_start(8'd4, 8'd1);
        tick();
        tick();
        check_val("st_c3", {24'd0, enable, wr_addr}, {24'd0, 1'b1, 7'd2});
        stall = 1'b1;
        tick();
        check_val("st_c4", {24'd0, enable, wr_addr}, {24'd0, 1'b0, 7'd2});
        tick();
        check_val("st_c5", {24'd0, enable, wr_addr}, {24'd0, 1'b0, 7'd2});
        stall = 1'b0;
        tick();
        check_val("st_c6", {23'd0, enable, last_word, wr_addr}, {23'd0, 2'b11, 7'd3});
        check_val("st_c6_done", {31'd0, done}, 32'd0);
        tick();
        tick();
        check_val("st_c8_done", {31'd0, done}, 32'd1);
        tick();

        // zero iterations goes straight to done
        drive_start(8'd5, 8'd0);
        check_val("ni0_c1", {29'd0, enable, busy, done}, 32'd3);
        tick();
        check_val("ni0_c2", {30'd0, busy, done}, 32'd0);

        // start re-pulsed mid-run with different parameters is ignored
        drive_start(8'd2, 8'd3);
        tick();
        start     = 1'b1;
        num_words = 8'd5;
        num_iters = 8'd1;
        tick();
        start = 1'b0;
        check_val("ign_c3_en", {31'd0, enable}, 32'd0);
        tick();
        check_val("ign_c4", {24'd0, iter_cnt}, 32'd1);
        tick();
        check_val("ign_c5_addr", {25'd0, wr_addr}, 32'd1);
        tick();
        check_val("ign_c6", {23'd0, enable, iter_cnt}, {23'd0, 1'b0, 8'd2});
        repeat (3) tick();
        check_val("ign_c9_done", {31'd0, done}, 32'd0);
        tick();
        check_val("ign_c10_done", {31'd0, done}, 32'd1);
        tick();

        // abort at iteration 1, word 1
        drive_start(8'd3, 8'd3);
        repeat (5) tick();
        check_val("ab_c6_pos", {24'd0, iter_cnt[0], wr_addr}, {24'd0, 1'b1, 7'd1});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("ab_c7", {29'd0, busy, enable, done}, 32'd0);
        for (int c = 0; c < 12; c++) begin
            tick();
            check_val($sformatf("ab_nodone_%0d", c), {31'd0, done}, 32'd0);
        end
        drive_start(8'd2, 8'd1);
        check_val("ab_restart", {16'd0, enable, wr_addr, iter_cnt}, {16'd0, 1'b1, 7'd0, 8'd0});
        repeat (4) tick();

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        num_iters = 8'd2;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_val("sa_idle", {30'd0, busy, enable}, 32'd0);

        // asynchronous reset mid-sweep, between clock edges
        drive_start(8'd10, 8'd2);
        tick();
        tick();
        #1 asyn_reset = 1'b1;
        #1;
        check_val("arst_out", {16'd0, busy, enable, first_word, last_word, wr_addr[3:0], iter_cnt},
                  32'd0);
        check_val("arst_addr", {25'd0, rd_addr}, 32'd0);
        #1 asyn_reset = 1'b0;
        tick();
        check_val("arst_stay", {31'd0, busy}, 32'd0);

        // full-depth and clamped word counts, plus zero words treated as one
        run_long(8'd128, "nw128");
        run_long(8'd200, "nw200");
        drive_start(8'd0, 8'd1);
        check_val("nw0_c1", {29'd0, enable, first_word, last_word}, 32'd7);
        tick();
        tick();
        check_val("nw0_done", {31'd0, done}, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
